// File: rtl/rca_seq_ctrl_if.sv
// Operand/result handshake bundle for rca_seq_ctrl. Port ovf exists only when
// RCA_SEQ_OVF_EN is defined. Modport slave is the controller; master is the requester/consumer.
interface rca_seq_ctrl_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef RCA_SEQ_OVF_EN
    logic         ovf;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy, ovf
    );
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy, ovf
    );
`else
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/rca_seq_ctrl.sv
// Byte-serial wide adder: one 8-bit slice reused LSB-first with a registered carry.
// Optional signed-overflow flag (port ovf) is built when RCA_SEQ_OVF_EN is defined.
module rca_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    rca_seq_ctrl_if.slave    bus,
    output logic [1:0]       state_dbg
);
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [NBYTES-1:0][7:0] a_reg;
    logic [NBYTES-1:0][7:0] b_reg;
    logic [NBYTES-1:0][7:0] sum_reg;
    logic                   carry_reg;
    logic                   cout_reg;
    logic [IDX_W-1:0]       idx;

    logic [7:0] x1;
    logic [7:0] x2;
    logic [8:0] slice;
    logic       in_fire;
    logic       last_byte;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // the source holds valid and its payload stable until that edge, ready never depends on valid.
    assign in_fire   = bus.in_valid && (state == IDLE);
    assign last_byte = (idx == LAST_IDX);

    assign x1    = a_reg[idx];
    assign x2    = b_reg[idx];
    assign slice = {1'b0, x1} + {1'b0, x2} + {8'd0, carry_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_byte) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx       <= '0;
        end else if (in_fire) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
            sum_reg   <= '0;
            idx       <= '0;
        end else if (state == RUN) begin
            sum_reg[idx] <= slice[7:0];
            carry_reg    <= slice[8];
            if (last_byte) begin
                cout_reg <= slice[8];
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef RCA_SEQ_OVF_EN
    logic ovf_reg;

    // On the last byte x1/x2 are the operand top bytes, so this is the full-width signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if ((state == RUN) && last_byte) begin
            ovf_reg <= (x1[7] == x2[7]) && (slice[7] != x1[7]);
        end
    end

    assign bus.ovf = ovf_reg;
`endif

    assign bus.sum   = sum_reg;
    assign bus.cout  = cout_reg;
    assign state_dbg = state;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl (NBYTES=4); covers ovf when RCA_SEQ_OVF_EN is defined.
module tb_rca_seq_ctrl;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;

  rca_seq_ctrl_if #(.NBYTES(NB)) bus_if ();

  rca_seq_ctrl #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .state_dbg (state_dbg)
  );

  int total = 0;
  int bad   = 0;
  logic [W:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands until accepted; records {cout,sum} expected from plain arithmetic.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                      output int waits);
    logic acc;
    bus_if.in_valid = 1'b1;
    bus_if.a = x;
    bus_if.b = y;
    bus_if.cin = c;
    waits = 0;
    acc = 1'b0;
    while (!acc && waits < 40) begin
      acc = bus_if.in_ready;
      tick();
      if (!acc) waits++;
    end
    bus_if.in_valid = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      waits = -1;
      $display("FAIL accept_timeout: in_ready never seen for a=%h b=%h", x, y);
    end else begin
      exp_q.push_back({1'b0, x} + {1'b0, y} + {{W{1'b0}}, c});
    end
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!bus_if.out_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    total++;
    if (!bus_if.out_valid) begin
      bad++;
      $display("FAIL out_timeout: out_valid=%b required 1 within 40 cycles", bus_if.out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.a = '0;
    bus_if.b = '0;
    bus_if.cin = 1'b0;
    bus_if.out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({bus_if.in_ready, bus_if.out_valid, bus_if.busy, bus_if.cout} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags: rdy/vld/busy/cout=%b required 1000",
               {bus_if.in_ready, bus_if.out_valid, bus_if.busy, bus_if.cout});
    end
    total++;
    if (bus_if.sum !== '0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset_sum_state: sum=%h state=%0d required 0/0", bus_if.sum, state_dbg);
    end
`ifdef RCA_SEQ_OVF_EN
    total++;
    if (bus_if.ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf: ovf=%b required 0", bus_if.ovf);
    end
`endif
  endtask

  task automatic test_carry_ripple();
    int w;
    logic [W:0] exp;
    logic early;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, w);
    early = 1'b0;
    for (int k = 1; k < NB; k++) begin
      if (bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b1) early = 1'b1;
      tick();
    end
    total++;
    if (early) begin
      bad++;
      $display("FAIL ripple_run_phase: out_valid rose early or busy dropped, required vld=0 busy=1");
    end
    if (bus_if.out_valid !== 1'b1) tick();
    total++;
    if (bus_if.out_valid !== 1'b1 || bus_if.busy !== 1'b1) begin
      bad++;
      $display("FAIL ripple_latency: out_valid=%b busy=%b required 1/1 at edge %0d after accept",
               bus_if.out_valid, bus_if.busy, NB);
    end
    exp = exp_q.pop_front();
    total++;
    if ({bus_if.cout, bus_if.sum} !== exp) begin
      bad++;
      $display("FAIL ripple_result: got %h required %h", {bus_if.cout, bus_if.sum}, exp);
    end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    total++;
    if (bus_if.busy !== 1'b0 || bus_if.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ripple_release: busy=%b in_ready=%b required 0/1", bus_if.busy, bus_if.in_ready);
    end
  endtask

  task automatic test_carry_in();
    int w, cyc;
    logic [W:0] exp;
    logic rdy_seen;
    send(32'h1234_5678, 32'h1111_1111, 1'b1, w);
    bus_if.in_valid = 1'b1;
    bus_if.a = 32'hFFFF_FFFF;
    rdy_seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (bus_if.in_ready !== 1'b0) rdy_seen = 1'b1;
      tick();
    end
    bus_if.in_valid = 1'b0;
    total++;
    if (rdy_seen) begin
      bad++;
      $display("FAIL cin_in_ready_run: in_ready seen 1 during RUN, required 0");
    end
    wait_out(cyc);
    exp = exp_q.pop_front();
    total++;
    if ({bus_if.cout, bus_if.sum} !== exp || exp !== {1'b0, 32'h2345_678A}) begin
      bad++;
      $display("FAIL cin_result: got %h required %h", {bus_if.cout, bus_if.sum}, exp);
    end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    tick();
    total++;
    if (bus_if.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL cin_no_ghost: out_valid=%b required 0 (ignored in_valid started a job)",
               bus_if.out_valid);
    end
  endtask

  task automatic test_backpressure();
    int w, cyc;
    logic [W:0] exp;
    logic unstable;
    send(32'h5, 32'h3, 1'b0, w);
    wait_out(cyc);
    exp = exp_q.pop_front();
    unstable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (bus_if.out_valid !== 1'b1 || {bus_if.cout, bus_if.sum} !== exp) unstable = 1'b1;
      tick();
    end
    total++;
    if (unstable || exp !== 33'h8) begin
      bad++;
      $display("FAIL bp_hold: vld=%b got %h required 1/%h held", bus_if.out_valid,
               {bus_if.cout, bus_if.sum}, exp);
    end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    total++;
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1",
               bus_if.out_valid, bus_if.in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    int w, cyc, ghost;
    logic [W:0] exp;
    send(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, w);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    total++;
    if ({bus_if.out_valid, bus_if.busy, bus_if.cout} !== 3'b000 || bus_if.sum !== '0) begin
      bad++;
      $display("FAIL midrst_outputs: vld/busy/cout=%b sum=%h required 000/0",
               {bus_if.out_valid, bus_if.busy, bus_if.cout}, bus_if.sum);
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (bus_if.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_ready: in_ready=%b required 1", bus_if.in_ready);
    end
    ghost = 0;
    bus_if.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (bus_if.out_valid === 1'b1) ghost++;
      tick();
    end
    bus_if.out_ready = 1'b0;
    total++;
    if (ghost != 0) begin
      bad++;
      $display("FAIL midrst_ghost: out_valid seen %0d cycles required 0", ghost);
    end
    send(32'h1, 32'h1, 1'b0, w);
    wait_out(cyc);
    exp = exp_q.pop_front();
    total++;
    if ({bus_if.cout, bus_if.sum} !== exp) begin
      bad++;
      $display("FAIL midrst_next: got %h required %h", {bus_if.cout, bus_if.sum}, exp);
    end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int w, cyc;
    logic [W:0] exp;
    bus_if.out_ready = 1'b1;
    send(32'h1, 32'h2, 1'b0, w);
    wait_out(cyc);
    exp = exp_q.pop_front();
    total++;
    if ({bus_if.cout, bus_if.sum} !== exp) begin
      bad++;
      $display("FAIL b2b_first: got %h required %h", {bus_if.cout, bus_if.sum}, exp);
    end
    tick();
    send(32'hFFFF_0000, 32'h0001_0000, 1'b0, w);
    total++;
    if (w != 0) begin
      bad++;
      $display("FAIL b2b_accept_gap: extra wait cycles=%0d required 0", w);
    end
    wait_out(cyc);
    exp = exp_q.pop_front();
    total++;
    if ({bus_if.cout, bus_if.sum} !== exp || exp !== {1'b1, 32'h0}) begin
      bad++;
      $display("FAIL b2b_second: got %h required %h", {bus_if.cout, bus_if.sum}, exp);
    end
    tick();
    bus_if.out_ready = 1'b0;
  endtask

`ifdef RCA_SEQ_OVF_EN
  task automatic test_ovf();
    int w, cyc;
    logic [W:0] exp;
    bus_if.out_ready = 1'b0;
    send(32'h7FFF_FFFF, 32'h1, 1'b0, w);
    wait_out(cyc);
    exp = exp_q.pop_front();
    total++;
    if ({bus_if.ovf, bus_if.cout, bus_if.sum} !== {1'b1, exp}) begin
      bad++;
      $display("FAIL ovf_pos: ovf/cout/sum=%h required %h",
               {bus_if.ovf, bus_if.cout, bus_if.sum}, {1'b1, exp});
    end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    send(32'hFFFF_FFFF, 32'h1, 1'b0, w);
    wait_out(cyc);
    exp = exp_q.pop_front();
    total++;
    if ({bus_if.ovf, bus_if.cout, bus_if.sum} !== {1'b0, exp}) begin
      bad++;
      $display("FAIL ovf_wrap: ovf/cout/sum=%h required %h",
               {bus_if.ovf, bus_if.cout, bus_if.sum}, {1'b0, exp});
    end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
  endtask
`endif

  task automatic test_random();
    int w, cyc, errs;
    logic [W:0] exp;
    logic [W-1:0] x, y;
    errs = 0;
    for (int n = 0; n < 20; n++) begin
      x = {$urandom_range(65535, 0), $urandom_range(65535, 0)} ;
      y = {$urandom_range(65535, 0), $urandom_range(65535, 0)} ;
      if (n < 3) begin
        x = '1;
        y = '1;
      end
      repeat ($urandom_range(2, 0)) tick();
      send(x, y, 1'($urandom_range(1, 0)), w);
      wait_out(cyc);
      repeat ($urandom_range(3, 0)) tick();
      exp = exp_q.pop_front();
      total++;
      if ({bus_if.cout, bus_if.sum} !== exp) begin
        bad++;
        errs++;
        $display("FAIL rand_result[%0d]: got %h required %h", n, {bus_if.cout, bus_if.sum}, exp);
      end
      bus_if.out_ready = 1'b1;
      tick();
      bus_if.out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_carry_in();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
`ifdef RCA_SEQ_OVF_EN
    test_ovf();
`endif
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d results left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
